// File: rtl/mash_cic_decim_if.sv
// mash_cic_decim_if: sample-side controls and decimated output of mash_cic_decim
interface mash_cic_decim_if #(
  parameter int ACCUM_SIZE = 16
);
  logic                  sync_clr;
  logic                  en;
  logic [3:0]            sdm_in;
  logic [ACCUM_SIZE-1:0] dout;
  logic                  dout_valid;
  modport master (output sync_clr, en, sdm_in, input dout, dout_valid);
  modport slave (input sync_clr, en, sdm_in, output dout, dout_valid);
endinterface

// File: rtl/mash_cic_decim.sv
// mash_cic_decim: sinc^3 decimator turning the MASH code stream back into the SDM input word; MASH_DECIM_SAT_EN clamps dout
module mash_cic_decim #(
  parameter int ACCUM_SIZE = 16,
  parameter int DECIM_LOG2 = 6
) (
  input logic clk,
  input logic rst_n,
  mash_cic_decim_if.slave bus
);
  localparam int B = 4 + 3 * DECIM_LOG2;
  localparam int SH = 3 * DECIM_LOG2 - ACCUM_SIZE;
  if (3 * DECIM_LOG2 < ACCUM_SIZE) begin : g_bad_cfg
    $error("mash_cic_decim: 3*DECIM_LOG2 must be >= ACCUM_SIZE");
  end
  logic signed [B-1:0] x, i1, i2, i3, s, s_z, c1, c1_z, c2, c2_z, c3, y;
  logic [DECIM_LOG2-1:0] cnt;
  logic [4:0] stb;
  logic [1:0] warm;
  logic [ACCUM_SIZE-1:0] y_out, dout;
  logic dout_valid;
  assign x = {{(B - 4){bus.sdm_in[3]}}, bus.sdm_in};
  assign bus.dout = dout;
  assign bus.dout_valid = dout_valid;
`ifndef MASH_DECIM_SAT_EN
  logic unused_y;
  assign unused_y = ^y[B-1:ACCUM_SIZE];
`endif
  // Scale C3 to the output word: floor shift, then clamp or wrap
  always_comb begin
    y = c3 >>> SH;
`ifdef MASH_DECIM_SAT_EN
    y_out = y[B-1] ? '0 : (|y[B-2:ACCUM_SIZE]) ? '1 : y[ACCUM_SIZE-1:0];
`else
    y_out = y[ACCUM_SIZE-1:0];
`endif
  end
  // Integrator cascade and frame phase; each stage adds last cycle's value of the stage before it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {i1, i2, i3, cnt} <= '0;
    else if (bus.sync_clr) {i1, i2, i3, cnt} <= '0;
    else if (bus.en) begin
      i1 <= i1 + x;
      i2 <= i2 + i1;
      i3 <= i3 + i2;
      cnt <= cnt + 1'b1;
    end
  // Comb pipeline: a strobe walks one stage per clk, independent of en
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {stb, s, s_z, c1, c1_z, c2, c2_z, c3} <= '0;
    else if (bus.sync_clr) {stb, s, s_z, c1, c1_z, c2, c2_z, c3} <= '0;
    else begin
      stb <= {stb[3:0], bus.en & (&cnt)};
      if (stb[0]) s <= i3;
      if (stb[1]) begin
        c1 <= s - s_z;
        s_z <= s;
      end
      if (stb[2]) begin
        c2 <= c1 - c1_z;
        c1_z <= c1;
      end
      if (stb[3]) begin
        c3 <= c2 - c2_z;
        c2_z <= c2;
      end
    end
  // Output register; the first three decimated words after a clear are swallowed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {warm, dout, dout_valid} <= '0;
    else if (bus.sync_clr) {warm, dout, dout_valid} <= '0;
    else begin
      dout_valid <= stb[4] & (&warm);
      if (stb[4] & (&warm)) dout <= y_out;
      if (stb[4] & ~(&warm)) warm <= warm + 1'b1;
    end
endmodule
